// File: rtl/statemover_pkg.sv
// statemover_pkg -- shared constants and helpers for the state-mover target design.
//   BP_DISABLED        : breakpoint value that disables the compare
//   LFSR_MASK          : Galois feedback mask for x^32+x^22+x^2+x+1
//   LFSR_SEED_DEFAULT  : default non-zero workload LFSR reset value
//   lfsr_next()        : one Galois step (shift right, XOR mask when lsb was 1)
package statemover_pkg;

    localparam logic [31:0] BP_DISABLED       = 32'hFFFF_FFFF;
    localparam logic [31:0] LFSR_MASK         = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0000_ACE1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] sh;
        sh = s >> 1;
        return s[0] ? (sh ^ LFSR_MASK) : sh;
    endfunction

endpackage

// File: rtl/sm_workload.sv
// sm_workload -- deterministic workload: a Galois LFSR feeding an accumulator.
// Every state element is a plain flop so it can be dumped/restored while frozen.
// Ports:
//   clk_p     in   1   clock (posedge)
//   reset     in   1   synchronous active-high reset
//   run_en    in   1   advance enable; low holds every register
//   signature out  32  lfsr ^ acc
module sm_workload
    import statemover_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk_p,
    input  logic        reset,
    input  logic        run_en,
    output logic [31:0] signature
);

    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] acc_q,  acc_d;

    always_comb begin
        lfsr_d = lfsr_q;
        acc_d  = acc_q;
        if (run_en) begin
            lfsr_d = lfsr_next(lfsr_q);
            // Accumulate the pre-step LFSR value.
            acc_d  = acc_q + lfsr_q;
        end
    end

    always_ff @(posedge clk_p) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
            acc_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            acc_q  <= acc_d;
        end
    end

    assign signature = lfsr_q ^ acc_q;

endmodule

// File: rtl/statemover_top.sv
// statemover_top -- target design for state save/restore experiments.
// Runs the LFSR/accumulator workload and counts executed cycles. All state
// advances only while clk_en is high and no breakpoint is hit; freezing is
// enable-based (no clock gating).
// Build option: define BREAKPOINT_EN to enable the breakpoint compare; when
// undefined, halted is tied low and breakpoint is ignored.
// Ports:
//   clk_p        in   1      clock, positive leg (all logic on its posedge)
//   clk_n        in   1      negative leg, unused by logic
//   reset        in   1      synchronous active-high reset (beats clk_en/halted)
//   clk_en       in   1      run enable
//   breakpoint   in   CNT_W  halt when cycle_count equals it; all-ones disables
//   cycle_count  out  CNT_W  executed-cycle counter
//   halted       out  1      breakpoint reached (combinational)
//   signature    out  32     workload observation (lfsr ^ acc)
module statemover_top
    import statemover_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT,
    parameter int          CNT_W     = 32
) (
    input  logic             clk_p,
    input  logic             clk_n,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [CNT_W-1:0] breakpoint,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halted,
    output logic [31:0]      signature
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_en;

    // The differential partner carries no information the logic needs.
    logic unused_clk_n;
    assign unused_clk_n = clk_n;

`ifdef BREAKPOINT_EN
    localparam logic [CNT_W-1:0] BP_OFF = CNT_W'(BP_DISABLED);

    // Live compare: a new breakpoint value takes effect on the very next edge.
    // The counter can sit at all-ones, but that value never halts because it
    // is the disable code.
    assign halted = (breakpoint != BP_OFF) && (cnt_q == breakpoint);
`else
    logic unused_bp;
    assign unused_bp = ^breakpoint;
    assign halted    = 1'b0;
`endif

    assign run_en = clk_en && !halted && !reset;

    always_comb begin
        cnt_d = cnt_q;
        if (run_en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_p) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cycle_count = cnt_q;

    sm_workload #(
        .LFSR_SEED (LFSR_SEED)
    ) u_workload (
        .clk_p     (clk_p),
        .reset     (reset),
        .run_en    (run_en),
        .signature (signature)
    );

endmodule

// File: tb/tb_statemover_top.sv
// tb_statemover_top -- directed self-checking bench for statemover_top.
// A behavioural reference model predicts each edge; predictions go into a
// scoreboard queue before the edge and are popped and compared #1 after it.
// Breakpoint scenarios follow the BREAKPOINT_EN build option.
module tb_statemover_top;

    localparam logic [31:0] SEED  = 32'h0000_ACE1;
    localparam logic [31:0] MASK  = 32'h8020_0003;
    localparam logic [31:0] BPOFF = 32'hFFFF_FFFF;

    logic        clk_p = 1'b0;
    logic        clk_n;
    logic        reset;
    logic        clk_en;
    logic [31:0] breakpoint;
    logic [31:0] cycle_count;
    logic        halted;
    logic [31:0] signature;

    always #5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;

    statemover_top dut (
        .clk_p       (clk_p),
        .clk_n       (clk_n),
        .reset       (reset),
        .clk_en      (clk_en),
        .breakpoint  (breakpoint),
        .cycle_count (cycle_count),
        .halted      (halted),
        .signature   (signature)
    );

    typedef struct packed {
        logic [31:0] cnt;
        logic [31:0] sig;
        logic        hlt;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_cnt, m_lfsr, m_acc;

    function automatic logic m_halted();
`ifdef BREAKPOINT_EN
        return (breakpoint != BPOFF) && (m_cnt == breakpoint);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_cnt  = 32'd0;
            m_lfsr = SEED;
            m_acc  = 32'd0;
        end else if (clk_en && !m_halted()) begin
            m_cnt = m_cnt + 32'd1;
            m_acc = m_acc + m_lfsr;
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ MASK;
            else           m_lfsr = m_lfsr >> 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        chk("cycle_count", cycle_count, e.cnt);
        chk("signature", signature, e.sig);
        chk("halted", {31'd0, halted}, {31'd0, e.hlt});
    endtask

    // Predict one edge, push, clock, pop and compare.
    task automatic step();
        exp_t e;
        model_edge();
        e.cnt = m_cnt;
        e.sig = m_lfsr ^ m_acc;
        e.hlt = m_halted();
        sb.push_back(e);
        @(posedge clk_p);
        #1;
        compare_head();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Compare the present (combinational) view without an edge.
    task automatic check_now();
        exp_t e;
        #1;
        e.cnt = m_cnt;
        e.sig = m_lfsr ^ m_acc;
        e.hlt = m_halted();
        sb.push_back(e);
        compare_head();
    endtask

    logic [31:0] sig_hold;

    initial begin
        reset      = 1'b1;
        clk_en     = 1'b1;
        breakpoint = BPOFF;
        m_cnt      = 32'd0;
        m_lfsr     = SEED;
        m_acc      = 32'd0;

        // Long reset, then fixed known values.
        steps(500);
        chk("rst_cnt", cycle_count, 32'd0);
        chk("rst_sig", signature, 32'h0000_ACE1);
        chk("rst_halt", {31'd0, halted}, 32'd0);

        // First workload step worked by hand: lfsr 8020_5673, acc 0000_ACE1.
        reset = 1'b0;
        step();
        chk("first_sig", signature, 32'h8020_FA92);
        steps(9);
        chk("cnt_10", cycle_count, 32'd10);

        // Freeze at 100 for 4 edges, then resume.
        steps(90);
        chk("cnt_100", cycle_count, 32'd100);
        sig_hold = signature;
        clk_en = 1'b0;
        steps(4);
        chk("freeze_cnt", cycle_count, 32'd100);
        chk("freeze_sig", signature, sig_hold);
        clk_en = 1'b1;
        step();
        chk("resume_cnt", cycle_count, 32'd101);

        // Reset while frozen at 77 beats clk_en=0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        steps(77);
        clk_en = 1'b0;
        steps(2);
        chk("cnt_77", cycle_count, 32'd77);
        reset = 1'b1;
        step();
        chk("rst77_cnt", cycle_count, 32'd0);
        chk("rst77_sig", signature, 32'h0000_ACE1);
        reset  = 1'b0;
        clk_en = 1'b1;

`ifdef BREAKPOINT_EN
        // Halt at 50, signature frozen; move breakpoint to 60 and halt again.
        breakpoint = 32'd50;
        check_now();
        steps(60);
        chk("bp50_cnt", cycle_count, 32'd50);
        chk("bp50_halt", {31'd0, halted}, 32'd1);
        sig_hold = signature;
        steps(3);
        chk("bp50_sig", signature, sig_hold);
        breakpoint = 32'd60;
        check_now();
        chk("bp60_live", {31'd0, halted}, 32'd0);
        steps(20);
        chk("bp60_cnt", cycle_count, 32'd60);
        chk("bp60_halt", {31'd0, halted}, 32'd1);

        // Breakpoint 0 out of reset: halted immediately, never counts.
        breakpoint = 32'd0;
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(20);
        chk("bp0_cnt", cycle_count, 32'd0);
        chk("bp0_halt", {31'd0, halted}, 32'd1);
        chk("bp0_sig", signature, 32'h0000_ACE1);
`else
        // Breakpoint ignored in this build.
        breakpoint = 32'd50;
        steps(60);
        chk("nobp_cnt", cycle_count, 32'd60);
        chk("nobp_halt", {31'd0, halted}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
